// File: rtl/i2c_xfer_pkg.sv
// Shared types and constants for the single-transaction I2C master.
package i2c_xfer_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    AACK,
    WBYTE,
    WACK,
    RBYTE,
    MNACK,
    STOP
  } i2c_state_t;

  typedef logic [1:0] quarter_t;

  localparam int SLOT_QUARTERS = 4;
  localparam int BYTE_BITS     = 8;

  // Clocks per quarter-bit, truncated, never below one.
  function automatic int quarter_clocks(input int clk_hz, input int i2c_hz);
    int q;
    q = clk_hz / (4 * i2c_hz);
    return (q < 1) ? 1 : q;
  endfunction

endpackage

// File: rtl/i2c_xfer_tick.sv
// Quarter-bit tick divider: one-cycle tick every Q enabled clocks, cleared on demand.
module i2c_tick_gen #(
  parameter int Q = 25
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (Q > 1) ? $clog2(Q) : 1;
  localparam logic [CW-1:0] LAST = CW'(Q - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/i2c_xfer.sv
// Single-transaction open-drain I2C master: START, address+R/W, 1-2 write bytes or 1 read byte, STOP.
// Optional I2C_GLITCH_FILTER_EN adds a 3-sample majority filter on the synchronized SDA input.
module i2c_xfer
  import i2c_xfer_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int I2C_HZ = 500_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       read,
  input  logic [6:0] addr,
  input  logic       wlen,
  input  logic [7:0] wdata1,
  input  logic [7:0] wdata2,
  output logic [7:0] rdata,
  output logic       done,
  output logic       nack,
  output logic       scl,
  inout  wire        sda
);

  localparam int         Q        = quarter_clocks(CLK_HZ, I2C_HZ);
  localparam quarter_t   SAMPLE_Q = 2'd2;
  localparam quarter_t   LAST_Q   = quarter_t'(SLOT_QUARTERS - 1);
  localparam logic [2:0] LAST_BIT = 3'(BYTE_BITS - 1);

  i2c_state_t state, state_nxt;
  quarter_t   qtr, qtr_nxt;
  logic [2:0] bit_cnt, bit_cnt_nxt;
  logic       second, second_nxt;
  logic       done_nxt, nack_nxt;
  logic [7:0] rdata_nxt;
  logic       scl_low, sda_low, scl_low_nxt, sda_low_nxt;
  logic       start_q, start_qq, launch, tick;
  logic       sda_s1, sda_s2, sda_in;
  logic [7:0] shreg, shreg_nxt, rshift, rshift_nxt;
  logic       ack_r, ack_nxt;
  logic       rd_l, wlen_l;
  logic [7:0] wd1_l, wd2_l;

  // Pin drive for a given slot position; returns {scl_low, sda_low}.
  function automatic logic [1:0] bus_drive(input i2c_state_t st, input quarter_t q, input logic b);
    logic scl_l, sda_l;
    scl_l = (q == 2'd0) || (q == 2'd3);
    sda_l = 1'b0;
    case (st)
      IDLE:        scl_l = 1'b0;
      START: begin
        scl_l = (q == 2'd3);
        sda_l = (q >= 2'd2);
      end
      ADDR, WBYTE: sda_l = ~b;
      STOP: begin
        scl_l = (q == 2'd0);
        sda_l = (q != 2'd3);
      end
      default:     ;
    endcase
    return {scl_l, sda_l};
  endfunction

  assign scl = scl_low ? 1'b0 : 1'bz;
  assign sda = sda_low ? 1'b0 : 1'bz;

  assign launch = (state == IDLE) && start_q && !start_qq;

  i2c_tick_gen #(.Q(Q)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state != IDLE),
    .clr     (launch),
    .tick    (tick)
  );

`ifdef I2C_GLITCH_FILTER_EN
  logic [2:0] sda_hist;

  if (Q < 4) begin : g_q_too_small
    $error("i2c_xfer: SDA glitch filter needs at least 4 clocks per quarter bit");
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sda_hist <= 3'b111;
    else          sda_hist <= {sda_hist[1:0], sda_s2};
  end

  assign sda_in = (sda_hist[0] & sda_hist[1]) | (sda_hist[0] & sda_hist[2]) |
                  (sda_hist[1] & sda_hist[2]);
`else
  assign sda_in = sda_s2;
`endif

  always_comb begin
    state_nxt   = state;
    qtr_nxt     = qtr;
    bit_cnt_nxt = bit_cnt;
    second_nxt  = second;
    done_nxt    = done;
    nack_nxt    = nack;
    rdata_nxt   = rdata;
    shreg_nxt   = shreg;
    rshift_nxt  = rshift;
    ack_nxt     = ack_r;

    if (state == IDLE) begin
      if (launch) begin
        state_nxt   = START;
        qtr_nxt     = '0;
        bit_cnt_nxt = '0;
        second_nxt  = 1'b0;
        done_nxt    = 1'b0;
        nack_nxt    = 1'b0;
        shreg_nxt   = {addr, read};
      end
    end else if (tick) begin
      qtr_nxt = qtr + 2'd1;
      if (qtr == SAMPLE_Q) begin
        ack_nxt = sda_in;
        if (state == RBYTE) rshift_nxt = {rshift[6:0], sda_in};
      end
      // Slot boundary: every state transition happens here.
      if (qtr == LAST_Q) begin
        case (state)
          START: state_nxt = ADDR;
          ADDR, WBYTE: begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            shreg_nxt   = {shreg[6:0], 1'b0};
            if (bit_cnt == LAST_BIT) state_nxt = (state == ADDR) ? AACK : WACK;
          end
          AACK: begin
            if (ack_r) begin
              nack_nxt  = 1'b1;
              state_nxt = STOP;
            end else if (rd_l) begin
              state_nxt = RBYTE;
            end else begin
              state_nxt = WBYTE;
              shreg_nxt = wd1_l;
            end
          end
          WACK: begin
            if (ack_r) begin
              nack_nxt  = 1'b1;
              state_nxt = STOP;
            end else if (wlen_l && !second) begin
              state_nxt  = WBYTE;
              shreg_nxt  = wd2_l;
              second_nxt = 1'b1;
            end else begin
              state_nxt = STOP;
            end
          end
          RBYTE: begin
            bit_cnt_nxt = bit_cnt + 3'd1;
            if (bit_cnt == LAST_BIT) state_nxt = MNACK;
          end
          MNACK: begin
            rdata_nxt = rshift;
            state_nxt = STOP;
          end
          STOP: begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
          default: state_nxt = IDLE;
        endcase
      end
    end

    {scl_low_nxt, sda_low_nxt} = bus_drive(state_nxt, qtr_nxt, shreg_nxt[7]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      qtr      <= '0;
      bit_cnt  <= '0;
      second   <= 1'b0;
      done     <= 1'b1;
      nack     <= 1'b0;
      rdata    <= '0;
      scl_low  <= 1'b0;
      sda_low  <= 1'b0;
      start_q  <= 1'b0;
      start_qq <= 1'b0;
      sda_s1   <= 1'b1;
      sda_s2   <= 1'b1;
    end else begin
      state    <= state_nxt;
      qtr      <= qtr_nxt;
      bit_cnt  <= bit_cnt_nxt;
      second   <= second_nxt;
      done     <= done_nxt;
      nack     <= nack_nxt;
      rdata    <= rdata_nxt;
      scl_low  <= scl_low_nxt;
      sda_low  <= sda_low_nxt;
      start_q  <= start;
      start_qq <= start_q;
      sda_s1   <= sda;
      sda_s2   <= sda_s1;
    end
  end

  // Datapath registers are always written before use within a frame.
  always_ff @(posedge clk) begin
    shreg  <= shreg_nxt;
    rshift <= rshift_nxt;
    ack_r  <= ack_nxt;
    if (launch) begin
      rd_l   <= read;
      wlen_l <= wlen;
      wd1_l  <= wdata1;
      wd2_l  <= wdata2;
    end
  end

endmodule

// File: tb/tb_i2c_xfer.sv
// Directed bench for i2c_xfer with an open-drain bus, behavioural slave and bus decoder.
module tb_i2c_xfer;

  logic       clk = 1'b0;
  logic       reset_n, start, read, wlen;
  logic [6:0] addr;
  logic [7:0] wdata1, wdata2, rdata;
  logic       done, nack;
  wire        scl_bus, sda_bus;

  pullup (scl_bus);
  pullup (sda_bus);

  logic slv_sda_low = 1'b0;
  assign sda_bus = slv_sda_low ? 1'b0 : 1'bz;

  logic       slv_present;
  logic [6:0] slv_addr;
  logic [7:0] slv_rdat;

  i2c_xfer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .read    (read),
    .addr    (addr),
    .wlen    (wlen),
    .wdata1  (wdata1),
    .wdata2  (wdata2),
    .rdata   (rdata),
    .done    (done),
    .nack    (nack),
    .scl     (scl_bus),
    .sda     (sda_bus)
  );

  always #10 clk = ~clk;

  // Bus decoder and slave, one process so all of its state has a single writer.
  logic       scl_prev = 1'b1, sda_prev = 1'b1;
  int         nbits = 0, byte_idx = 0, mon_starts = 0, mon_stops = 0;
  logic       addressed = 1'b0, rd_mode = 1'b0, mon_mack = 1'b0;
  logic [7:0] mon_sh = '0;
  logic [7:0] mon_q[$];

  always @(scl_bus or sda_bus) begin
    if (scl_bus === 1'b1 && scl_prev === 1'b1 && sda_prev === 1'b1 && sda_bus === 1'b0) begin
      mon_starts++;
      nbits = 0; byte_idx = 0; addressed = 1'b0; rd_mode = 1'b0;
      mon_q.delete();
      slv_sda_low = 1'b0;
    end else if (scl_bus === 1'b1 && scl_prev === 1'b1 && sda_prev === 1'b0 && sda_bus === 1'b1) begin
      mon_stops++;
      nbits = 0;
      slv_sda_low = 1'b0;
    end else if (scl_prev !== 1'b1 && scl_bus === 1'b1) begin
      if (nbits < 8) mon_sh = {mon_sh[6:0], (sda_bus === 1'b1)};
      else           mon_mack = sda_bus;
      nbits++;
    end else if (scl_prev === 1'b1 && scl_bus !== 1'b1) begin
      if (nbits == 8) begin
        mon_q.push_back(mon_sh);
        if (byte_idx == 0) begin
          addressed   = slv_present && (mon_sh[7:1] == slv_addr);
          rd_mode     = mon_sh[0];
          slv_sda_low = addressed;
        end else begin
          slv_sda_low = addressed && !rd_mode;
        end
      end else if (nbits == 9) begin
        nbits = 0;
        byte_idx++;
        slv_sda_low = (addressed && rd_mode && byte_idx == 1) ? ~slv_rdat[7] : 1'b0;
      end else if (nbits >= 1 && nbits <= 7 && addressed && rd_mode && byte_idx == 1) begin
        slv_sda_low = ~slv_rdat[7 - nbits];
      end
    end
    scl_prev = scl_bus;
    sda_prev = sda_bus;
  end

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic chk_rng(input string tag, input int got, input int lo, input int hi);
    n_chk++;
    assert (got >= lo && got <= hi) n_pass++;
    else $error("FAIL %s: got %0d, expected %0d..%0d", tag, got, lo, hi);
  endtask

  function automatic logic [7:0] q_at(input int i);
    return (mon_q.size() > i) ? mon_q[i] : 8'hxx;
  endfunction

  // Launch one transaction and count clocks with done low; leaves start high.
  task automatic do_xfer(input logic rd, input logic [6:0] a, input logic wl,
                         input logic [7:0] d1, input logic [7:0] d2,
                         output logic fall_ok, output int cyc);
    logic d_first, d_second;
    start = 1'b0;
    repeat (3) @(negedge clk);
    read = rd; addr = a; wlen = wl; wdata1 = d1; wdata2 = d2;
    start = 1'b1;
    @(negedge clk); d_first  = done;
    @(negedge clk); d_second = done;
    fall_ok = (d_first === 1'b1) && (d_second === 1'b0);
    cyc = (d_second === 1'b0) ? 1 : 0;
    while (done === 1'b0 && cyc < 6000) begin
      @(negedge clk);
      if (done === 1'b0) cyc++;
    end
  endtask

  initial begin
    int   cyc, s_st, s_sp;
    logic fall_ok;

    reset_n = 1'b0; start = 1'b0; read = 1'b0; addr = '0; wlen = 1'b0;
    wdata1 = '0; wdata2 = '0;
    slv_present = 1'b1; slv_addr = 7'h20; slv_rdat = 8'hA8;
    repeat (3) @(negedge clk);
    chk("rst_done", done, 1);
    chk("rst_nack", nack, 0);
    chk("rst_rdata", rdata, 8'h00);
    chk("rst_scl", scl_bus, 1);
    chk("rst_sda", sda_bus, 1);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Two-byte write, slave ACKs everything; start then held high past completion.
    s_st = mon_starts; s_sp = mon_stops;
    do_xfer(1'b0, 7'h20, 1'b1, 8'h05, 8'h24, fall_ok, cyc);
    chk("wr2_done_fall", fall_ok, 1);
    chk_rng("wr2_len", cyc, 2897, 2903);
    chk("wr2_nbytes", mon_q.size(), 3);
    chk("wr2_b0", q_at(0), 8'h40);
    chk("wr2_b1", q_at(1), 8'h05);
    chk("wr2_b2", q_at(2), 8'h24);
    chk("wr2_starts", mon_starts - s_st, 1);
    chk("wr2_stops", mon_stops - s_sp, 1);
    chk("wr2_nack", nack, 0);
    repeat (100) @(negedge clk);
    chk("hold_done", done, 1);
    chk("hold_starts", mon_starts - s_st, 1);

    // Read one byte.
    s_sp = mon_stops;
    do_xfer(1'b1, 7'h20, 1'b0, 8'h00, 8'h00, fall_ok, cyc);
    chk_rng("rd_len", cyc, 1997, 2003);
    chk("rd_nbytes", mon_q.size(), 2);
    chk("rd_b0", q_at(0), 8'h41);
    chk("rd_b1", q_at(1), 8'hA8);
    chk("rd_mnack", mon_mack, 1);
    chk("rd_rdata", rdata, 8'hA8);
    chk("rd_nack", nack, 0);
    chk("rd_stops", mon_stops - s_sp, 1);

    // Absent slave: address NACK aborts straight to STOP.
    slv_present = 1'b0;
    s_sp = mon_stops;
    do_xfer(1'b0, 7'h33, 1'b0, 8'h77, 8'h00, fall_ok, cyc);
    chk_rng("an_len", cyc, 1097, 1103);
    chk("an_nbytes", mon_q.size(), 1);
    chk("an_b0", q_at(0), 8'h66);
    chk("an_nack", nack, 1);
    chk("an_rdata", rdata, 8'hA8);
    chk("an_stops", mon_stops - s_sp, 1);
    do_xfer(1'b1, 7'h33, 1'b0, 8'h00, 8'h00, fall_ok, cyc);
    chk_rng("anr_len", cyc, 1097, 1103);
    chk("anr_nack", nack, 1);
    chk("anr_rdata", rdata, 8'hA8);
    slv_present = 1'b1;

    // One-byte write; nack must clear at launch.
    do_xfer(1'b0, 7'h20, 1'b0, 8'h5A, 8'hEE, fall_ok, cyc);
    chk_rng("wr1_len", cyc, 1997, 2003);
    chk("wr1_nbytes", mon_q.size(), 2);
    chk("wr1_b1", q_at(1), 8'h5A);
    chk("wr1_nack", nack, 0);

    // start toggled mid-frame must not queue a second frame.
    start = 1'b0;
    repeat (3) @(negedge clk);
    s_st = mon_starts;
    read = 1'b0; addr = 7'h20; wlen = 1'b0; wdata1 = 8'h11;
    start = 1'b1;
    repeat (500) @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    start = 1'b1;
    cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("tog_done", done, 1);
    repeat (100) @(negedge clk);
    chk("tog_idle", done, 1);
    chk("tog_starts", mon_starts - s_st, 1);
    chk("tog_b1", q_at(1), 8'h11);
    do_xfer(1'b0, 7'h20, 1'b0, 8'h3C, 8'h00, fall_ok, cyc);
    chk("tog_next_fall", fall_ok, 1);
    chk("tog_next_starts", mon_starts - s_st, 2);
    chk("tog_next_b1", q_at(1), 8'h3C);

    // Reset during address bit 2 (master pulling SCL and SDA low).
    start = 1'b0;
    repeat (3) @(negedge clk);
    read = 1'b0; addr = 7'h20; wlen = 1'b1; wdata1 = 8'hA5; wdata2 = 8'h5A;
    start = 1'b1;
    repeat (312) @(negedge clk);
    chk("prerst_scl", scl_bus, 0);
    chk("prerst_sda", sda_bus, 0);
    reset_n = 1'b0;
    start = 1'b0;
    #1;
    chk("rstmid_scl", scl_bus, 1);
    chk("rstmid_sda", sda_bus, 1);
    chk("rstmid_done", done, 1);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    do_xfer(1'b0, 7'h20, 1'b0, 8'hC3, 8'h00, fall_ok, cyc);
    chk_rng("post_len", cyc, 1997, 2003);
    chk("post_b0", q_at(0), 8'h40);
    chk("post_b1", q_at(1), 8'hC3);
    chk("post_nack", nack, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
